// File: rtl/picosoc_led_pwm.sv
// picosoc_led_pwm: memory-mapped LED controller for the picosoc native bus.
// Each LED has a direct on/off bit and an 8-bit PWM brightness.
// A global blink generator can gate all LEDs on and off together.
// Bus accesses complete with a single-cycle mem_ready pulse one cycle after the request.

module picosoc_led_pwm #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
    parameter int          PRESCALE  = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [7:0]  led
);

    // Prescaler width; a PRESCALE of 1 still needs a one-bit counter that stays at zero
    localparam int             PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);

    logic        sel;
    logic        is_write;
    logic [5:0]  word;
    logic        wr_ctrl;
    logic        wr_out;
    logic        wr_dlo;
    logic        wr_dhi;
    logic        wr_blink;
    logic [31:0] rd_val;

    logic [1:0]  ctrl;
    logic [7:0]  led_out;
    logic [7:0]  duty [8];
    logic [23:0] blink_half;
    logic        blink_phase;
    logic [23:0] blink_cnt;
    logic [23:0] blink_last;

    logic [PW-1:0] presc;
    logic [7:0]    pwm_cnt;
    logic          step;
    logic          frame;
    logic [7:0]    pwm_on;
    logic [7:0]    led_next;

    // The two byte-offset bits are not used for decoding; registers are word aligned
    logic unused_addr;
    assign unused_addr = ^mem_addr[1:0];

    // The !mem_ready term keeps a held request from being answered twice
    assign sel      = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]) && !mem_ready;
    assign is_write = |mem_wstrb;
    assign word     = mem_addr[7:2];
    assign wr_ctrl  = sel && is_write && (word == 6'h00);
    assign wr_out   = sel && is_write && (word == 6'h01);
    assign wr_dlo   = sel && is_write && (word == 6'h02);
    assign wr_dhi   = sel && is_write && (word == 6'h03);
    assign wr_blink = sel && is_write && (word == 6'h04);

    assign step       = (presc == PRESC_LAST);
    assign frame      = step && (pwm_cnt == 8'hFF);
    assign blink_last = (blink_half == 24'd0) ? 24'd0 : (blink_half - 24'd1);

    // Read-data mux; unused bits and unmapped offsets read as zero
    always_comb begin
        rd_val = 32'h0;
        case (word)
            6'h00:   rd_val = {30'h0, ctrl};
            6'h01:   rd_val = {24'h0, led_out};
            6'h02:   rd_val = {duty[3], duty[2], duty[1], duty[0]};
            6'h03:   rd_val = {duty[7], duty[6], duty[5], duty[4]};
            6'h04:   rd_val = {8'h0, blink_half};
            6'h05:   rd_val = {16'h0, pwm_cnt, 7'h0, blink_phase};
            default: rd_val = 32'h0;
        endcase
    end

    // Bus response: one-cycle ready pulse, read data only alongside a read's ready
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0;
        end else begin
            mem_ready <= sel;
            mem_rdata <= (sel && !is_write) ? rd_val : 32'h0;
        end
    end

    // Control, output and duty registers, written per byte lane
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl       <= 2'b01;
            led_out    <= 8'h00;
            blink_half <= 24'd1;
            for (int i = 0; i < 8; i++) begin
                duty[i] <= 8'hFF;
            end
        end else begin
            if (wr_ctrl && mem_wstrb[0]) begin
                ctrl <= mem_wdata[1:0];
            end
            if (wr_out && mem_wstrb[0]) begin
                led_out <= mem_wdata[7:0];
            end
            for (int i = 0; i < 4; i++) begin
                if (wr_dlo && mem_wstrb[i]) begin
                    duty[i] <= mem_wdata[8*i +: 8];
                end
                if (wr_dhi && mem_wstrb[i]) begin
                    duty[i+4] <= mem_wdata[8*i +: 8];
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (wr_blink && mem_wstrb[i]) begin
                    blink_half[8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Prescaler and PWM counter; a PWM wrap marks the end of a frame
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc   <= '0;
            pwm_cnt <= 8'h00;
        end else begin
            presc <= step ? '0 : presc + 1'b1;
            if (step) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
        end
    end

    // Blink generator; a BLINK write restarts the period and overrides a coincident frame tick
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blink_cnt   <= 24'd0;
            blink_phase <= 1'b1;
        end else if (wr_blink) begin
            blink_cnt   <= 24'd0;
            blink_phase <= 1'b1;
        end else if (frame) begin
            if (blink_cnt == blink_last) begin
                blink_cnt   <= 24'd0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 24'd1;
            end
        end
    end

    // Combined LED enable: duty 0xFF is fully on with no one-step gap
    always_comb begin
        pwm_on = 8'h00;
        for (int i = 0; i < 8; i++) begin
            pwm_on[i] = (duty[i] == 8'hFF) || (pwm_cnt < duty[i]);
        end
        led_next = {8{ctrl[0] & (~ctrl[1] | blink_phase)}} & led_out & pwm_on;
    end

    // Registered LED drive
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led <= 8'h00;
        end else begin
            led <= led_next;
        end
    end

endmodule
